mips_state_dump: RTL and testbench
==================================

Name: mips_state_dump

Overview:
- Post-run state scan-out engine that sits directly downstream of the MIPS_SCP core.
- On a start pulse it walks the data memory, instruction memory, heap RAM and register file in that order, and emits one (region, address, data) beat per word on a valid/ready stream.
- The bench, or a UART/trace sink, consumes this stream instead of reaching into the hierarchy.
- Reads go through plain combinational read ports on the existing arrays; the core must be halted while busy is high.

Parameters:
- DMEM_WORDS, 64, number of data-memory words dumped
- IMEM_WORDS, 64, number of instruction-memory words dumped
- HMEM_WORDS, 64, number of heap-RAM words dumped
- NUM_REGS, 32, number of register-file entries dumped
- DMEM_BASE, 32'h10010000, byte address reported for DMEM word 0
- IMEM_BASE, 32'h00000000, byte address reported for IMEM word 0
- HMEM_BASE, 32'h10000000, byte address reported for HMEM word 0
- IDX_W, 8, width of the read index; must hold max(word counts)-1

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a dump; ignored while busy
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse after the final beat is accepted
- rd_sel  output  2  region being read: 0=DMEM, 1=IMEM, 2=HMEM, 3=REGS
- rd_idx  output  IDX_W  word index or register number being read
- dmem_rd_data  input  32  combinational DMEM word at rd_idx
- imem_rd_data  input  32  combinational IMEM word at rd_idx
- hmem_rd_data  input  32  combinational HMEM word at rd_idx
- reg_rd_data  input  32  combinational register value at rd_idx
- out_valid  output  1  beat valid
- out_ready  input  1  sink accepts the beat when out_valid and out_ready are both high
- out_region  output  2  region code of the beat
- out_addr  output  32  byte address for memories (BASE + idx*4), register number for REGS
- out_data  output  32  captured word

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, out_region=0, out_addr=0, out_data=0, rd_sel=0, rd_idx=0; FSM in IDLE.
- FSM states: IDLE, DMEM, IMEM, HMEM, REGS, FLUSH.
- IDLE:
  - start=1 moves to DMEM with idx=0 and raises busy next cycle.
- Region states:
  - rd_sel is the region code; rd_idx is the current idx.
  - Load condition: (!out_valid || out_ready).
  - On load, capture region, address and the selected rd_data into the out registers, set out_valid=1 and increment idx.
  - If idx == WORDS-1 on a load, clear idx and advance: DMEM->IMEM->HMEM->REGS->FLUSH.
- Output stream:
  - out_valid deasserts only on an accepting handshake with no new load in the same cycle.
  - While out_valid=1 and out_ready=0, the beat is held stable: region, addr and data do not change.
- FLUSH:
  - Waits for the last beat to be accepted.
  - On acceptance: out_valid=0, done=1 for one cycle, busy=0, return to IDLE.
- Latency and throughput:
  - start to first out_valid is 2 cycles (cycle 1: enter DMEM; cycle 2: first load registered).
  - With out_ready held high, throughput is one beat per cycle.
  - Total beats = DMEM_WORDS+IMEM_WORDS+HMEM_WORDS+NUM_REGS (224 by default).
- Address arithmetic: out_addr = BASE + {idx,2'b00}, 32-bit wrap. REGS: out_addr = zero-extended idx.
- Simultaneous events:
  - start while busy is ignored; the dump in progress is unaffected.
  - start arriving in the same cycle done pulses is ignored; a new start is accepted from the next cycle.
- Reset mid-dump: asynchronously returns every output to its reset value and the FSM to IDLE; no done pulse is produced.
- A zero word-count parameter is illegal.

Test Plan:
- Defaults, DMEM[0]=0xDEADBEEF, REG[31]=0x00400018, out_ready=1, start pulse -> first beat 2 cycles later: region 0, addr 0x10010000, data 0xDEADBEEF. 224 consecutive beats; last beat region 3, addr 31, data 0x00400018; done pulses one cycle after the last beat.
- Boundary beats with out_ready=1 -> beat 63 has addr 0x100100FC; beat 64 is region 1, addr 0x00000000; beat 128 is region 2, addr 0x10000000; beat 192 is region 3, addr 0.
- out_ready low for 5 cycles at beat 10 -> out_valid stays 1 and region/addr/data stay constant; no beat is lost or duplicated, and indices are sequential on resume.
- Random out_ready with 50% duty -> exactly 224 handshakes, addresses strictly in order, done asserts exactly once.
- start pulsed again at beat 100 -> ignored; total remains 224 beats.
- reset asserted at beat 150, then released -> out_valid=0 and busy=0 immediately, no done pulse. A fresh start restarts at DMEM addr 0x10010000.

Source files
------------

// File: rtl/mips_state_dump.sv
// Post-run scan-out engine: walks DMEM, IMEM, heap RAM and the register file
// and streams one (region, address, data) beat per word over valid/ready.
module mips_state_dump #(
  parameter int          DMEM_WORDS = 64,
  parameter int          IMEM_WORDS = 64,
  parameter int          HMEM_WORDS = 64,
  parameter int          NUM_REGS   = 32,
  parameter logic [31:0] DMEM_BASE  = 32'h10010000,
  parameter logic [31:0] IMEM_BASE  = 32'h00000000,
  parameter logic [31:0] HMEM_BASE  = 32'h10000000,
  parameter int          IDX_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [1:0]       rd_sel,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [31:0]      dmem_rd_data,
  input  logic [31:0]      imem_rd_data,
  input  logic [31:0]      hmem_rd_data,
  input  logic [31:0]      reg_rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_region,
  output logic [31:0]      out_addr,
  output logic [31:0]      out_data
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DMEM  = 3'd1,
    IMEM  = 3'd2,
    HMEM  = 3'd3,
    REGS  = 3'd4,
    FLUSH = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] DMEM_LAST = IDX_W'(DMEM_WORDS - 1);
  localparam logic [IDX_W-1:0] IMEM_LAST = IDX_W'(IMEM_WORDS - 1);
  localparam logic [IDX_W-1:0] HMEM_LAST = IDX_W'(HMEM_WORDS - 1);
  localparam logic [IDX_W-1:0] REGS_LAST = IDX_W'(NUM_REGS - 1);

  state_t           state, state_next, adv_state;
  logic [IDX_W-1:0] idx, idx_next, last_idx;
  logic             load, done_next, in_region;
  logic [1:0]       region;
  logic [31:0]      base, word, beat_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      done  <= done_next;
    end
  end

  // A start coinciding with the done pulse is dropped so back-to-back dumps
  // always see at least one idle cycle between them.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    load       = 1'b0;
    done_next  = 1'b0;
    in_region  = 1'b0;
    region     = 2'd0;
    base       = 32'd0;
    word       = 32'd0;
    last_idx   = '0;
    adv_state  = IDLE;
    case (state)
      IDLE: begin
        if (start && !done) begin
          state_next = DMEM;
          idx_next   = '0;
        end
      end
      DMEM: begin
        in_region = 1'b1;
        region    = 2'd0;
        base      = DMEM_BASE;
        word      = dmem_rd_data;
        last_idx  = DMEM_LAST;
        adv_state = IMEM;
      end
      IMEM: begin
        in_region = 1'b1;
        region    = 2'd1;
        base      = IMEM_BASE;
        word      = imem_rd_data;
        last_idx  = IMEM_LAST;
        adv_state = HMEM;
      end
      HMEM: begin
        in_region = 1'b1;
        region    = 2'd2;
        base      = HMEM_BASE;
        word      = hmem_rd_data;
        last_idx  = HMEM_LAST;
        adv_state = REGS;
      end
      REGS: begin
        in_region = 1'b1;
        region    = 2'd3;
        word      = reg_rd_data;
        last_idx  = REGS_LAST;
        adv_state = FLUSH;
      end
      FLUSH: begin
        if (out_valid && out_ready) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // The output register refills whenever it is empty or being drained.
    if (in_region) begin
      load = !out_valid || out_ready;
      if (load) begin
        if (idx == last_idx) begin
          idx_next   = '0;
          state_next = adv_state;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
    end
  end

  assign beat_addr = (state == REGS) ? 32'(idx) : base + (32'(idx) << 2);

  // Beat register: holds stable while the sink stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_region <= 2'd0;
      out_addr   <= 32'd0;
      out_data   <= 32'd0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_region <= region;
      out_addr   <= beat_addr;
      out_data   <= word;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign busy   = (state != IDLE);
  assign rd_sel = region;
  assign rd_idx = idx;

endmodule

// File: tb/tb_mips_state_dump.sv
// Self-checking bench for mips_state_dump: random memory contents, varied
// sink back-pressure, restart/reset corner cases against a beat-list model.
module tb_mips_state_dump;

  localparam int TOTAL = 224;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [1:0]  rd_sel;
  logic [7:0]  rd_idx;
  logic [31:0] dmem_rd_data;
  logic [31:0] imem_rd_data;
  logic [31:0] hmem_rd_data;
  logic [31:0] reg_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_region;
  logic [31:0] out_addr;
  logic [31:0] out_data;

  logic [31:0] dmem [256];
  logic [31:0] imem [256];
  logic [31:0] hmem [256];
  logic [31:0] regs [256];

  logic [1:0]  exp_region [TOTAL];
  logic [31:0] exp_addr   [TOTAL];
  logic [31:0] exp_data   [TOTAL];

  int vectors = 0;
  int miscompares = 0;
  int n, dones, last_hs, done_cyc, first_valid;

  mips_state_dump dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .rd_sel       (rd_sel),
    .rd_idx       (rd_idx),
    .dmem_rd_data (dmem_rd_data),
    .imem_rd_data (imem_rd_data),
    .hmem_rd_data (hmem_rd_data),
    .reg_rd_data  (reg_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_region   (out_region),
    .out_addr     (out_addr),
    .out_data     (out_data)
  );

  always #5 clk = ~clk;

  // Read ports return a sentinel when the engine is not selecting that array.
  assign dmem_rd_data = (rd_sel == 2'd0) ? dmem[rd_idx] : 32'hBAD0BAD0;
  assign imem_rd_data = (rd_sel == 2'd1) ? imem[rd_idx] : 32'hBAD1BAD1;
  assign hmem_rd_data = (rd_sel == 2'd2) ? hmem[rd_idx] : 32'hBAD2BAD2;
  assign reg_rd_data  = (rd_sel == 2'd3) ? regs[rd_idx] : 32'hBAD3BAD3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic build_model();
    for (int i = 0; i < TOTAL; i++) begin
      if (i < 64) begin
        exp_region[i] = 2'd0;
        exp_addr[i]   = 32'h10010000 + 32'(4 * i);
        exp_data[i]   = dmem[i];
      end else if (i < 128) begin
        exp_region[i] = 2'd1;
        exp_addr[i]   = 32'(4 * (i - 64));
        exp_data[i]   = imem[i - 64];
      end else if (i < 192) begin
        exp_region[i] = 2'd2;
        exp_addr[i]   = 32'h10000000 + 32'(4 * (i - 128));
        exp_data[i]   = hmem[i - 128];
      end else begin
        exp_region[i] = 2'd3;
        exp_addr[i]   = 32'(i - 192);
        exp_data[i]   = regs[i - 192];
      end
    end
  endtask

  // mode 0: ready high; 1: 5-cycle stall at beat 10; 2: random ready;
  // 3: ready high with a second start at beat 100. abort_at >= 0 stops early.
  task automatic run_dump(input int mode, input int abort_at);
    int cyc, stall;
    bit held, stalled, restarted;
    logic [1:0]  h_region;
    logic [31:0] h_addr, h_data;
    n = 0; dones = 0; last_hs = -1; done_cyc = -1; first_valid = -1;
    cyc = 0; stall = 0; held = 0; stalled = 0; restarted = 0;
    h_region = 2'd0; h_addr = 32'd0; h_data = 32'd0;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk); cyc = 1; start = 1'b0;
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_valid_c1", 32'(out_valid), 32'd0);
    while (cyc < 3000) begin
      if (held) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_region", 32'(out_region), 32'(h_region));
        check("hold_addr", out_addr, h_addr);
        check("hold_data", out_data, h_data);
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        break;
      end
      if (abort_at >= 0 && n == abort_at) break;
      if (out_valid && first_valid < 0) first_valid = cyc;
      start = 1'b0;
      case (mode)
        1: begin
          if (n == 10 && !stalled && out_valid) begin
            stall = 5;
            stalled = 1;
          end
          if (stall > 0) begin
            out_ready = 1'b0;
            stall--;
          end else begin
            out_ready = 1'b1;
          end
        end
        2: out_ready = 1'($urandom_range(0, 1));
        3: begin
          out_ready = 1'b1;
          if (n == 100 && !restarted) begin
            start = 1'b1;
            restarted = 1;
          end
        end
        default: out_ready = 1'b1;
      endcase
      if (out_valid && out_ready) begin
        if (n >= TOTAL) begin
          check("extra_beat", 32'(n), 32'(TOTAL - 1));
        end else begin
          check($sformatf("beat%0d_region", n), 32'(out_region), 32'(exp_region[n]));
          check($sformatf("beat%0d_addr", n), out_addr, exp_addr[n]);
          check($sformatf("beat%0d_data", n), out_data, exp_data[n]);
        end
        if (n == 0) begin
          check("b0_addr", out_addr, 32'h10010000);
          check("b0_data", out_data, 32'hDEADBEEF);
        end
        if (n == 63) check("b63_addr", out_addr, 32'h100100FC);
        if (n == 64) begin
          check("b64_region", 32'(out_region), 32'd1);
          check("b64_addr", out_addr, 32'h00000000);
        end
        if (n == 128) begin
          check("b128_region", 32'(out_region), 32'd2);
          check("b128_addr", out_addr, 32'h10000000);
        end
        if (n == 192) begin
          check("b192_region", 32'(out_region), 32'd3);
          check("b192_addr", out_addr, 32'd0);
        end
        if (n == 223) begin
          check("b223_region", 32'(out_region), 32'd3);
          check("b223_addr", out_addr, 32'd31);
          check("b223_data", out_data, 32'h00400018);
        end
        n++;
        last_hs = cyc;
      end
      held = out_valid && !out_ready;
      h_region = out_region;
      h_addr = out_addr;
      h_data = out_data;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic post_checks(input string tag);
    check({tag, "_beats"}, 32'(n), 32'(TOTAL));
    check({tag, "_dones"}, 32'(dones), 32'd1);
    check({tag, "_first_valid_cyc"}, 32'(first_valid), 32'd2);
    check({tag, "_done_after_last"}, 32'(done_cyc), 32'(last_hs + 1));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_valid_at_done"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i] = $urandom;
      imem[i] = $urandom;
      hmem[i] = $urandom;
      regs[i] = $urandom;
    end
    dmem[0]  = 32'hDEADBEEF;
    regs[31] = 32'h00400018;
    build_model();

    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_region", 32'(out_region), 32'd0);
    check("rst_addr", out_addr, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_rd_sel", 32'(rd_sel), 32'd0);
    check("rst_rd_idx", 32'(rd_idx), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_dump(0, -1);
    post_checks("full");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_at_done_busy", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    @(negedge clk);

    run_dump(1, -1);
    post_checks("stall");
    @(negedge clk);
    run_dump(2, -1);
    post_checks("random");
    @(negedge clk);
    run_dump(3, -1);
    post_checks("restart");
    @(negedge clk);

    run_dump(0, 150);
    check("abort_beats", 32'(n), 32'd150);
    check("abort_valid_before", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_addr", out_addr, 32'd0);
    check("abort_rd_idx", 32'(rd_idx), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end

    run_dump(0, -1);
    post_checks("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
